regfile_writeback: RTL

- Writeback controller that owns the single register-file write port (RegWrite/rd/write_data) and arbitrates two result sources into it.
- Source 1 is the single-cycle ALU path. Source 2 is the variable-latency memory/long-op path, buffered in a small FIFO.
- Keeps a per-register busy scoreboard for issued long-latency ops so the hazard logic can stall dependent reads.
- Sits between execute/memory stages and the register file.

---
 rtl/regfile_writeback.sv | 126 ++++++++++++
 1 files changed

// File: rtl/regfile_writeback.sv
// Writeback arbiter for the single register-file write port: ALU results vs. a FIFO of memory/long-op results,
// with a starvation override for the FIFO head and a per-register busy scoreboard for issued long ops.
module regfile_writeback #(
    parameter int XLEN         = 32,
    parameter int AW           = 5,
    parameter int QDEPTH       = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     alu_valid,
    input  logic [AW-1:0]            alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    output logic                     alu_stall,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [AW-1:0]            mem_rd,
    input  logic [XLEN-1:0]          mem_data,
    input  logic                     issue_valid,
    input  logic [AW-1:0]            issue_rd,
    output logic [2**AW-1:0]         busy,
    output logic                     RegWrite,
    output logic [AW-1:0]            rd,
    output logic [XLEN-1:0]          write_data,
    output logic [$clog2(QDEPTH):0]  queue_count
);
    localparam int PW   = $clog2(QDEPTH);
    localparam int CW   = PW + 1;
    localparam int SW   = $clog2(STARVE_LIMIT + 1);
    localparam int NREG = 2**AW;

    logic [AW-1:0]   q_rd_q  [QDEPTH];
    logic [XLEN-1:0] q_dat_q [QDEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic            we_q;
    logic [AW-1:0]   rd_q;
    logic [XLEN-1:0] wd_q;

    logic empty, full, force_pop, alu_take, alu_wr, pop, push;
    logic [AW-1:0] head_rd;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(QDEPTH));
    assign force_pop = !empty && (starve_q >= SW'(STARVE_LIMIT));
    assign alu_take  = alu_valid && (alu_rd != '0);
    assign pop       = !empty && (force_pop || !alu_take);
    assign alu_wr    = alu_take && !force_pop;
    assign head_rd   = q_rd_q[rd_ptr_q];

    // Readiness looks only at occupancy so upstream never sees a same-cycle pop dependency.
    assign mem_ready = !reset && !full;
    assign alu_stall = !reset && force_pop && alu_valid;
    assign push      = mem_valid && mem_ready && (mem_rd != '0);

    always_comb begin
        busy_d = busy_q;
        if (pop)
            busy_d[head_rd] = 1'b0;
        if (issue_valid && (issue_rd != '0))
            busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        starve_d = starve_q;
        if (pop || empty)
            starve_d = '0;
        else if (starve_q < SW'(STARVE_LIMIT))
            starve_d = starve_q + 1'b1;
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clock) begin
        if (push) begin
            q_rd_q[wr_ptr_q]  <= mem_rd;
            q_dat_q[wr_ptr_q] <= mem_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            busy_q   <= '0;
            we_q     <= 1'b0;
            rd_q     <= '0;
            wd_q     <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q  <= count_d;
            starve_q <= starve_d;
            busy_q   <= busy_d;
            we_q     <= alu_wr || pop;
            // Index and data hold their last value on idle cycles.
            if (alu_wr) begin
                rd_q <= alu_rd;
                wd_q <= alu_data;
            end else if (pop) begin
                rd_q <= head_rd;
                wd_q <= q_dat_q[rd_ptr_q];
            end
        end
    end

    assign RegWrite    = we_q;
    assign rd          = rd_q;
    assign write_data  = wd_q;
    assign busy        = busy_q;
    assign queue_count = count_q;

endmodule
